// File: rtl/alarm_controller.sv
// Anti-theft car alarm FSM driving a countdown timer client.
// Programmable 4-entry delay table; all outputs are registered.
module alarm_controller #(
  parameter int unsigned T_ARM_DELAY       = 6,
  parameter int unsigned T_DRIVER_DELAY    = 8,
  parameter int unsigned T_PASSENGER_DELAY = 15,
  parameter int unsigned T_ALARM_ON        = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       driver_door,
  input  logic       passenger_door,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       expired_pulse,
  input  logic       one_hz,
  output logic       start_timer,
  output logic [3:0] value,
  output logic       siren,
  output logic       status_indicator,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    ALARM      = 3'd2,
    ALARM_HOLD = 3'd3,
    DISARMED   = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARMING     = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic [3:0] value_q, value_d;
  logic       siren_q, siren_d;
  logic       led_q, led_d;
  logic [3:0] tbl_q [4];
  logic [3:0] tbl_d [4];
  logic       any_open;

  assign any_open = driver_door | passenger_door;

  // Next state, timer start request, table write and output values.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    value_d = value_q;
    tbl_d   = tbl_q;
    if (reprogram) begin
      tbl_d[time_param_sel] = time_value;
      state_d = ARMED;
    end else if (ignition) begin
      state_d = DISARMED;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (driver_door) begin
            state_d = TRIGGERED;
            start_d = 1'b1;
            value_d = tbl_q[1];
          end else if (passenger_door) begin
            state_d = TRIGGERED;
            start_d = 1'b1;
            value_d = tbl_q[2];
          end
        end
        TRIGGERED: begin
          if (expired_pulse) state_d = ALARM;
        end
        ALARM: begin
          if (!any_open) begin
            state_d = ALARM_HOLD;
            start_d = 1'b1;
            value_d = tbl_q[3];
          end
        end
        ALARM_HOLD: begin
          if (any_open) state_d = ALARM;
          else if (expired_pulse) state_d = ARMED;
        end
        DISARMED: begin
          if (driver_door) state_d = WAIT_CLOSE;
        end
        WAIT_CLOSE: begin
          if (!any_open) begin
            state_d = ARMING;
            start_d = 1'b1;
            value_d = tbl_q[0];
          end
        end
        ARMING: begin
          if (any_open) state_d = WAIT_CLOSE;
          else if (expired_pulse) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end

    siren_d = (state_d == ALARM) || (state_d == ALARM_HOLD);

    // LED blinks only while staying in ARMED; entering ARMED clears it.
    unique case (state_d)
      TRIGGERED, ALARM, ALARM_HOLD: led_d = 1'b1;
      ARMED: begin
        if (state_q == ARMED && !reprogram) led_d = led_q ^ one_hz;
        else led_d = 1'b0;
      end
      default: led_d = 1'b0;
    endcase
  end

  // State, outputs and delay table registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ARMED;
      start_q  <= 1'b0;
      value_q  <= 4'd0;
      siren_q  <= 1'b0;
      led_q    <= 1'b0;
      tbl_q[0] <= 4'(T_ARM_DELAY);
      tbl_q[1] <= 4'(T_DRIVER_DELAY);
      tbl_q[2] <= 4'(T_PASSENGER_DELAY);
      tbl_q[3] <= 4'(T_ALARM_ON);
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      value_q <= value_d;
      siren_q <= siren_d;
      led_q   <= led_d;
      tbl_q   <= tbl_d;
    end
  end

  assign start_timer      = start_q;
  assign value            = value_q;
  assign siren            = siren_q;
  assign status_indicator = led_q;
  assign state_out        = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed vector table,
// async reset check, then random stimulus vs a reference model.
module tb_alarm_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       ignition, driver_door, passenger_door;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired_pulse, one_hz;
  logic       start_timer;
  logic [3:0] value;
  logic       siren, status_indicator;
  logic [2:0] state_out;

  int n_chk = 0;
  int n_fail = 0;

  alarm_controller dut (
    .clock(clock), .reset(reset),
    .ignition(ignition), .driver_door(driver_door),
    .passenger_door(passenger_door), .reprogram(reprogram),
    .time_param_sel(time_param_sel), .time_value(time_value),
    .expired_pulse(expired_pulse), .one_hz(one_hz),
    .start_timer(start_timer), .value(value), .siren(siren),
    .status_indicator(status_indicator), .state_out(state_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic ign, dd, pd, rp;
    logic [1:0] sel;
    logic [3:0] tv;
    logic ex, hz;
    int st, stt, val, sir, led;
  } vec_t;

  vec_t vecs[$];

  // Reference model: states as plain integers 0..6.
  int m_st, m_start, m_val, m_sir, m_led;
  int m_tbl[4];

  task automatic model_reset();
    m_st = 0; m_start = 0; m_val = 0; m_sir = 0; m_led = 0;
    m_tbl[0] = 6; m_tbl[1] = 8; m_tbl[2] = 15; m_tbl[3] = 10;
  endtask

  task automatic model_step();
    int nx;
    bit open;
    open = driver_door || passenger_door;
    nx = m_st;
    if (reprogram) begin
      nx = 0;
    end else if (ignition) begin
      nx = 4;
    end else begin
      if (m_st == 0 && open) nx = 1;
      if (m_st == 1 && expired_pulse) nx = 2;
      if (m_st == 2 && !open) nx = 3;
      if (m_st == 3) nx = open ? 2 : (expired_pulse ? 0 : 3);
      if (m_st == 4 && driver_door) nx = 5;
      if (m_st == 5 && !open) nx = 6;
      if (m_st == 6) nx = open ? 5 : (expired_pulse ? 0 : 6);
    end
    // A countdown starts whenever TRIGGERED, ALARM_HOLD or ARMING is entered.
    m_start = (nx != m_st) && (nx == 1 || nx == 3 || nx == 6);
    if (m_start) begin
      if (nx == 1) m_val = driver_door ? m_tbl[1] : m_tbl[2];
      else if (nx == 3) m_val = m_tbl[3];
      else m_val = m_tbl[0];
    end
    m_sir = (nx == 2 || nx == 3);
    if (nx >= 1 && nx <= 3) m_led = 1;
    else if (nx == 0 && m_st == 0 && !reprogram) m_led = m_led ^ int'(one_hz);
    else m_led = 0;
    if (reprogram) m_tbl[time_param_sel] = int'(time_value);
    m_st = nx;
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, int st, int stt, int val, int sir, int led);
    chk({tag, " state"}, int'(state_out), st);
    chk({tag, " start"}, int'(start_timer), stt);
    chk({tag, " value"}, int'(value), val);
    chk({tag, " siren"}, int'(siren), sir);
    chk({tag, " led"}, int'(status_indicator), led);
  endtask

  task automatic drive(logic ig, logic dd, logic pd, logic rp,
                       logic [1:0] sel, logic [3:0] tv, logic ex, logic hz);
    ignition = ig; driver_door = dd; passenger_door = pd;
    reprogram = rp; time_param_sel = sel; time_value = tv;
    expired_pulse = ex; one_hz = hz;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  function automatic vec_t mk(logic ig, logic dd, logic pd, logic rp,
                              logic [1:0] sel, logic [3:0] tv, logic ex,
                              logic hz, int st, int stt, int val, int sir,
                              int led);
    vec_t v;
    v.ign = ig; v.dd = dd; v.pd = pd; v.rp = rp; v.sel = sel; v.tv = tv;
    v.ex = ex; v.hz = hz; v.st = st; v.stt = stt; v.val = val;
    v.sir = sir; v.led = led;
    return v;
  endfunction

  initial begin
    //                ig dd pd rp sel tv  ex hz   st stt val sir led
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0,   1, 1, 8,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,   1, 0, 8,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0,   2, 0, 8,  1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,   3, 1, 10, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0,   2, 0, 10, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,   3, 1, 10, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0,   0, 0, 10, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 3,  0, 0,   0, 0, 10, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0,   1, 1, 3,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,   1, 0, 3,  0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 2, 15, 1, 0,   0, 0, 3,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0,   4, 0, 3,  0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0,   5, 0, 3,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,   6, 1, 6,  0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 0,   5, 0, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,   6, 1, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0,   0, 0, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1,   0, 0, 6,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0,   0, 0, 6,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1,   0, 0, 6,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1,   0, 0, 6,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 0,   0, 0, 6,  0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,  0, 0,   1, 1, 8,  0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0,   0, 0, 8,  0, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    reset = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].ign, vecs[i].dd, vecs[i].pd, vecs[i].rp,
            vecs[i].sel, vecs[i].tv, vecs[i].ex, vecs[i].hz);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].stt,
              vecs[i].val, vecs[i].sir, vecs[i].led);
    end

    // Table entry 0 was zeroed by the last vector; restore it.
    drive(0, 0, 0, 1, 0, 6, 0, 0);
    step();
    // Reach ALARM_HOLD, then reset asynchronously between edges.
    drive(0, 1, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk_all("hold", 3, 1, 10, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    model_reset();
    #1;
    reset = 1'b0;
    // Stale expiry from the abandoned countdown is ignored.
    drive(0, 0, 0, 0, 0, 0, 1, 0); step();
    chk_all("stale_exp", 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 4,
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)),
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 30);
      step();
      chk_all("rand", m_st, m_start, m_val, m_sir, m_led);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
